cam_pwr_seq: RTL and testbench

Camera power-up sequencer for the camera test path. It sits directly downstream of the microsecond clock divider. It consumes the divider's slow toggling output as a time-base tick and drives the camera's power-down, reset and XCLK-enable pins through a timed power-on sequence. When the sequence completes it raises `ready` for the SCCB/config logic that follows.

---
 rtl/cam_pwr_seq.sv | 140 ++++++++++++++
 tb/tb_cam_pwr_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pwr_seq.sv
// rtl/cam_pwr_seq.sv - camera power-up sequencer driven by the microsecond tick
module cam_pwr_seq #(
    parameter int T_PWDN = 1000,            // ticks after power-down release before XCLK
    parameter int T_XCLK = 10,              // ticks of XCLK before reset release
    parameter int T_RST  = 1000,            // ticks after reset release before ready
    parameter int CNT_W  = 16               // tick counter width
) (
    input  logic clk_in,                    // system clock
    input  logic reset,                     // asynchronous, active-high
    input  logic clk_1us,                   // divider output, one tick per rising edge
    input  logic start,                     // begin sequence (IDLE only)
    input  logic shutdown,                  // abort / power down (any state)
    output logic cam_pwdn,                  // 1 = camera powered down
    output logic cam_rst_n,                 // camera reset, active-low
    output logic cam_xclk_en,               // XCLK gate enable
    output logic busy,                      // sequence in progress
    output logic ready                      // sequence complete
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWR_UP,
        S_XCLK_ON,
        S_RST_REL,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] PWDN_LAST = CNT_W'(T_PWDN - 1);
    localparam logic [CNT_W-1:0] XCLK_LAST = CNT_W'(T_XCLK - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clk_1us_q;
    logic             tick;

    logic cam_pwdn_nxt;
    logic cam_rst_n_nxt;
    logic cam_xclk_en_nxt;
    logic busy_nxt;
    logic ready_nxt;

    // The delayed copy resets high so a divider output that is already high
    // when reset releases is not mistaken for a fresh rising edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clk_1us_q <= 1'b1;
            tick      <= 1'b0;
        end else begin
            clk_1us_q <= clk_1us;
            tick      <= clk_1us & ~clk_1us_q;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cam_pwdn    <= 1'b1;
            cam_rst_n   <= 1'b0;
            cam_xclk_en <= 1'b0;
            busy        <= 1'b0;
            ready       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cam_pwdn    <= cam_pwdn_nxt;
            cam_rst_n   <= cam_rst_n_nxt;
            cam_xclk_en <= cam_xclk_en_nxt;
            busy        <= busy_nxt;
            ready       <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (shutdown) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start)                     state_nxt = S_PWR_UP;
                S_PWR_UP:  if (tick && cnt == PWDN_LAST)  state_nxt = S_XCLK_ON;
                S_XCLK_ON: if (tick && cnt == XCLK_LAST)  state_nxt = S_RST_REL;
                S_RST_REL: if (tick && cnt == RST_LAST)   state_nxt = S_DONE;
                S_DONE:                                   state_nxt = S_DONE;
                default:                                  state_nxt = S_IDLE;
            endcase
        end
    end

    // A tick on the exit cycle is absorbed by the clear, so the new state
    // starts counting from its first tick after entry.
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (tick && (state == S_PWR_UP || state == S_XCLK_ON ||
                              state == S_RST_REL)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Outputs decode the next state so pins move on the entering edge.
    always_comb begin
        cam_pwdn_nxt    = 1'b1;
        cam_rst_n_nxt   = 1'b0;
        cam_xclk_en_nxt = 1'b0;
        busy_nxt        = 1'b0;
        ready_nxt       = 1'b0;
        case (state_nxt)
            S_PWR_UP: begin
                cam_pwdn_nxt = 1'b0;
                busy_nxt     = 1'b1;
            end
            S_XCLK_ON: begin
                cam_pwdn_nxt    = 1'b0;
                cam_xclk_en_nxt = 1'b1;
                busy_nxt        = 1'b1;
            end
            S_RST_REL: begin
                cam_pwdn_nxt    = 1'b0;
                cam_rst_n_nxt   = 1'b1;
                cam_xclk_en_nxt = 1'b1;
                busy_nxt        = 1'b1;
            end
            S_DONE: begin
                cam_pwdn_nxt    = 1'b0;
                cam_rst_n_nxt   = 1'b1;
                cam_xclk_en_nxt = 1'b1;
                ready_nxt       = 1'b1;
            end
            default: begin
                cam_pwdn_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cam_pwr_seq.sv
// tb/tb_cam_pwr_seq.sv - self-checking bench for cam_pwr_seq
module tb_cam_pwr_seq;

    logic clk_in = 1'b0;
    logic reset;
    logic clk_1us;
    logic start;
    logic shutdown;
    logic cam_pwdn, cam_rst_n, cam_xclk_en, busy, ready;

    int n_cmp = 0;
    int n_bad = 0;

    cam_pwr_seq #(.T_PWDN(3), .T_XCLK(2), .T_RST(4), .CNT_W(4)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .clk_1us     (clk_1us),
        .start       (start),
        .shutdown    (shutdown),
        .cam_pwdn    (cam_pwdn),
        .cam_rst_n   (cam_rst_n),
        .cam_xclk_en (cam_xclk_en),
        .busy        (busy),
        .ready       (ready)
    );

    always #5 clk_in = ~clk_in;

    wire [4:0] dut_out = {cam_pwdn, cam_rst_n, cam_xclk_en, busy, ready};
    localparam logic [4:0] IDLE_OUT = 5'b10000;

    // 10-cycle divider waveform, 5 high / 5 low
    logic gen_en = 1'b0;
    int   gph = 0;
    always @(negedge clk_in) begin
        if (gen_en) begin
            gph = (gph + 1) % 10;
            clk_1us = (gph < 5);
        end
    end

    // Reference: phase 0 idle, 1..3 timed phases with tick budgets, 4 done.
    int   dur [1:3] = '{3, 2, 4};
    int   m_ph, m_seen;
    logic m_prev, m_tick, m_nt;
    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_seen = 0; m_prev = 1'b1; m_tick = 1'b0;
        end else begin
            m_nt   = clk_1us & ~m_prev;
            m_prev = clk_1us;
            if (shutdown) begin
                m_ph = 0; m_seen = 0;
            end else if (m_ph == 0) begin
                if (start) begin m_ph = 1; m_seen = 0; end
            end else if (m_ph <= 3 && m_tick) begin
                m_seen++;
                if (m_seen == dur[m_ph]) begin m_ph++; m_seen = 0; end
            end
            m_tick = m_nt;
        end
    end

    function automatic logic [4:0] exp_out(input int ph);
        return {ph == 0, ph >= 3, ph >= 2, (ph >= 1 && ph <= 3), ph == 4};
    endfunction

    task automatic test_reset();
        gen_en = 1'b0; clk_1us = 1'b1; start = 1'b0; shutdown = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            n_cmp++;
            if (dut_out !== IDLE_OUT) begin
                n_bad++; $display("FAIL reset_outputs: got %b want %b", dut_out, IDLE_OUT);
            end
            n_cmp++;
            if (dut.tick !== 1'b0) begin
                n_bad++; $display("FAIL reset_no_tick: got %b want 0", dut.tick);
            end
        end
        gph = 4; gen_en = 1'b1;
    endtask

    task automatic test_full_seq();
        int c1 = 0, c2 = 0, c3 = 0;
        logic prev_busy = 1'b0;
        logic got = 1'b0;
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        n_cmp++;
        if (!(busy === 1'b1 && cam_pwdn === 1'b0)) begin
            n_bad++; $display("FAIL start_latency: got busy=%b pwdn=%b want 1/0", busy, cam_pwdn);
        end
        for (int i = 0; i < 200 && !got; i++) begin
            n_cmp++;
            if (dut_out !== exp_out(m_ph)) begin
                n_bad++; $display("FAIL full_seq_cycle: got %b want %b", dut_out, exp_out(m_ph));
            end
            if (ready) begin
                got = 1'b1;
                n_cmp++;
                if (!(prev_busy === 1'b1 && busy === 1'b0)) begin
                    n_bad++; $display("FAIL busy_fall: got prev=%b now=%b want 1/0", prev_busy, busy);
                end
            end else begin
                if (dut.tick) begin
                    if (busy && !cam_xclk_en) c1++;
                    else if (busy && !cam_rst_n) c2++;
                    else if (busy) c3++;
                end
                prev_busy = busy;
                @(negedge clk_in);
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL full_seq_timeout: got ready=0 want 1");
        end
        n_cmp++;
        if (c1 != 3 || c2 != 2 || c3 != 4) begin
            n_bad++; $display("FAIL phase_ticks: got %0d/%0d/%0d want 3/2/4", c1, c2, c3);
        end
        repeat (25) begin
            @(negedge clk_in);
            n_cmp++;
            if (dut_out !== 5'b01101) begin
                n_bad++; $display("FAIL ready_hold: got %b want 01101", dut_out);
            end
        end
        shutdown = 1'b1; @(negedge clk_in); shutdown = 1'b0;
        n_cmp++;
        if (dut_out !== IDLE_OUT) begin
            n_bad++; $display("FAIL shutdown_done: got %b want %b", dut_out, IDLE_OUT);
        end
    endtask

    task automatic test_abort();
        logic seen = 1'b0, hit = 1'b0;
        int c1 = 0;
        start = 1'b1; @(negedge clk_in); start = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk_in);
            if (cam_xclk_en && !cam_rst_n) begin
                if (seen) hit = 1'b1;
                else if (dut.tick) seen = 1'b1;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++; $display("FAIL abort_timeout: got no XCLK_ON tick want one");
        end
        n_cmp++;
        if (dut.cnt !== 4'd1) begin
            n_bad++; $display("FAIL abort_cnt_before: got %0d want 1", dut.cnt);
        end
        shutdown = 1'b1; @(negedge clk_in); shutdown = 1'b0;
        n_cmp++;
        if (dut_out !== IDLE_OUT || dut.cnt !== 4'd0) begin
            n_bad++; $display("FAIL abort_idle: got %b cnt=%0d want %b cnt=0", dut_out, dut.cnt, IDLE_OUT);
        end
        start = 1'b1; @(negedge clk_in); start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            n_cmp++;
            if (dut_out !== exp_out(m_ph)) begin
                n_bad++; $display("FAIL abort_restart_cycle: got %b want %b", dut_out, exp_out(m_ph));
            end
            if (cam_xclk_en) hit = 1'b1;
            else begin
                if (busy && dut.tick) c1++;
                @(negedge clk_in);
            end
        end
        n_cmp++;
        if (!hit || c1 != 3) begin
            n_bad++; $display("FAIL abort_restart_ticks: got %0d want 3", c1);
        end
        shutdown = 1'b1; @(negedge clk_in); shutdown = 1'b0;
    endtask

    task automatic test_priority();
        int c3 = 0;
        logic hit = 1'b0;
        start = 1'b1; shutdown = 1'b1; @(negedge clk_in); start = 1'b0; shutdown = 1'b0;
        repeat (3) begin
            n_cmp++;
            if (dut_out !== IDLE_OUT) begin
                n_bad++; $display("FAIL prio_idle: got %b want %b", dut_out, IDLE_OUT);
            end
            @(negedge clk_in);
        end
        start = 1'b1; @(negedge clk_in); start = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk_in);
            if (cam_rst_n && busy && dut.tick) begin
                if (c3 == 3) hit = 1'b1;
                else c3++;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++; $display("FAIL prio_timeout: got %0d RST_REL ticks want terminal", c3);
        end
        shutdown = 1'b1; @(negedge clk_in); shutdown = 1'b0;
        repeat (30) begin
            n_cmp++;
            if (dut_out !== IDLE_OUT) begin
                n_bad++; $display("FAIL prio_terminal: got %b want %b", dut_out, IDLE_OUT);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_mid_reset();
        logic hit = 1'b0;
        start = 1'b1; @(negedge clk_in); start = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk_in);
            if (cam_rst_n && busy) hit = 1'b1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++; $display("FAIL mreset_timeout: got no RST_REL want RST_REL");
        end
        #2 reset = 1'b1; start = 1'b1;
        #1;
        n_cmp++;
        if (dut_out !== IDLE_OUT) begin
            n_bad++; $display("FAIL mreset_async: got %b want %b", dut_out, IDLE_OUT);
        end
        repeat (3) begin
            @(negedge clk_in);
            n_cmp++;
            if (dut_out !== IDLE_OUT) begin
                n_bad++; $display("FAIL mreset_hold: got %b want %b", dut_out, IDLE_OUT);
            end
        end
        start = 1'b0; reset = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            n_cmp++;
            if (dut_out !== IDLE_OUT) begin
                n_bad++; $display("FAIL mreset_after: got %b want %b", dut_out, IDLE_OUT);
            end
        end
    endtask

    task automatic test_entry_tick();
        logic hit = 1'b0;
        int c1 = 0, c2 = 0, c3 = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk_in);
            if (dut.tick) hit = 1'b1;
        end
        start = 1'b1; @(negedge clk_in); start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            n_cmp++;
            if (dut_out !== exp_out(m_ph)) begin
                n_bad++; $display("FAIL entry_cycle: got %b want %b", dut_out, exp_out(m_ph));
            end
            if (ready) hit = 1'b1;
            else begin
                if (dut.tick) begin
                    if (busy && !cam_xclk_en) c1++;
                    else if (busy && !cam_rst_n) c2++;
                    else if (busy) c3++;
                end
                @(negedge clk_in);
            end
        end
        n_cmp++;
        if (!hit || c1 != 3 || c2 != 2 || c3 != 4) begin
            n_bad++; $display("FAIL entry_ticks: got %0d/%0d/%0d want 3/2/4", c1, c2, c3);
        end
        shutdown = 1'b1; @(negedge clk_in); shutdown = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 19) == 0);
            shutdown = ($urandom_range(0, 149) == 0);
            @(negedge clk_in);
            n_cmp++;
            if (dut_out !== exp_out(m_ph)) begin
                n_bad++; $display("FAIL random_cycle %0d: got %b want %b", i, dut_out, exp_out(m_ph));
            end
        end
        start = 1'b0; shutdown = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_seq();
        test_abort();
        test_priority();
        test_mid_reset();
        test_entry_tick();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
